mult8x8_seq_ctrl: RTL and testbench

MULT8X8_SEQ_CTRL -- requirements
Module: mult8x8_seq_ctrl

---
 rtl/mult8x8_seq_ctrl_if.sv | 22 ++
 rtl/mult8x8_seq_ctrl.sv | 144 ++++++++++++++
 tb/tb_mult8x8_seq_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mult8x8_seq_ctrl_if.sv
// Request/operand and result/register-control bundle for mult8x8_seq_ctrl.
// master drives the request and operands; slave (the multiplier) drives everything else.
interface mult8x8_seq_ctrl_if;
  logic        start;
  logic [7:0]  dataa;
  logic [7:0]  datab;
  logic [15:0] product;
  logic        reg_clk_ena;
  logic        reg_sclr_n;
  logic        busy;
  logic        done_flag;

  modport master (
    output start, dataa, datab,
    input  product, reg_clk_ena, reg_sclr_n, busy, done_flag
  );

  modport slave (
    input  start, dataa, datab,
    output product, reg_clk_ena, reg_sclr_n, busy, done_flag
  );
endinterface

// File: rtl/mult8x8_seq_ctrl.sv
// 8x8 multiplier built from one 4x4 multiplier over four nibble steps. The result appears 5 cycles after start; start is ignored while busy.
// Signed operands are enabled by defining MULT_SIGNED_EN; the default build is unsigned.
module mult8x8_seq_ctrl (
  input  logic               clk,
  input  logic               reset_n,
  mult8x8_seq_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LSB,
    S_MID1,
    S_MID2,
    S_MSB,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [15:0] acc_q, acc_d;

  logic        accept;
  logic [3:0]  nib_a, nib_b;
  logic [7:0]  pp;
  logic [15:0] pp_sh;
  logic [15:0] sum;

`ifdef MULT_SIGNED_EN
  logic sign_q, sign_d;

  // 0x80 maps to 0x80, which reads correctly as magnitude 128 when treated as unsigned.
  function automatic logic [7:0] mag8(input logic [7:0] v);
    return v[7] ? (~v + 8'd1) : v;
  endfunction
`endif

  assign accept = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    nib_a = a_q[3:0];
    nib_b = b_q[3:0];
    case (state_q)
      S_MID1:  nib_a = a_q[7:4];
      S_MID2:  nib_b = b_q[7:4];
      S_MSB: begin
        nib_a = a_q[7:4];
        nib_b = b_q[7:4];
      end
      default: ;
    endcase
  end

  assign pp = {4'b0000, nib_a} * {4'b0000, nib_b};

  always_comb begin
    pp_sh = 16'h0000;
    case (state_q)
      S_LSB:         pp_sh = {8'h00, pp};
      S_MID1, S_MID2: pp_sh = {4'h0, pp, 4'h0};
      S_MSB:         pp_sh = {pp, 8'h00};
      default:       ;
    endcase
  end

  assign sum = acc_q + pp_sh;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
`ifdef MULT_SIGNED_EN
    sign_d  = sign_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
`ifdef MULT_SIGNED_EN
          a_d    = mag8(bus.dataa);
          b_d    = mag8(bus.datab);
          sign_d = bus.dataa[7] ^ bus.datab[7];
`else
          a_d    = bus.dataa;
          b_d    = bus.datab;
`endif
          acc_d   = 16'h0000;
          state_d = S_LSB;
        end
      end
      S_LSB: begin
        acc_d   = sum;
        state_d = S_MID1;
      end
      S_MID1: begin
        acc_d   = sum;
        state_d = S_MID2;
      end
      S_MID2: begin
        acc_d   = sum;
        state_d = S_MSB;
      end
      S_MSB: begin
`ifdef MULT_SIGNED_EN
        acc_d   = sign_q ? (~sum + 16'd1) : sum;
`else
        acc_d   = sum;
`endif
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      acc_q   <= 16'h0000;
`ifdef MULT_SIGNED_EN
      sign_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
`ifdef MULT_SIGNED_EN
      sign_q  <= sign_d;
`endif
    end
  end

  // Outputs are decoded from state or read straight from registers, never from the inputs.
  assign bus.product     = acc_q;
  assign bus.busy        = (state_q == S_LSB) || (state_q == S_MID1) ||
                           (state_q == S_MID2) || (state_q == S_MSB);
  assign bus.done_flag   = (state_q == S_DONE);
  assign bus.reg_clk_ena = (state_q == S_LSB) || (state_q == S_DONE);
  assign bus.reg_sclr_n  = (state_q != S_LSB);

endmodule

// File: tb/tb_mult8x8_seq_ctrl.sv
// Directed and random checks of mult8x8_seq_ctrl against a plain-arithmetic product model.
module tb_mult8x8_seq_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  int   tests = 0;
  int   fails = 0;

  mult8x8_seq_ctrl_if bus ();

  mult8x8_seq_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
`ifdef MULT_SIGNED_EN
    int sa = a[7] ? int'(a) - 256 : int'(a);
    int sb = b[7] ? int'(b) - 256 : int'(b);
    return 16'(sa * sb);
`else
    return 16'(int'(a) * int'(b));
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic launch(input logic [7:0] a, input logic [7:0] b);
    bus.start = 1'b1;
    bus.dataa = a;
    bus.datab = b;
  endtask

  // Called at the negedge where start is already driven; after the first edge the
  // operand inputs are replaced with na/nb, which must not disturb the operation.
  task automatic wait_done(input string tag, input logic [15:0] exp, input bit hold,
                           input logic [7:0] na, input logic [7:0] nb);
    int       cyc    = 0;
    int       busy_n = 0;
    bit       seen   = 0;
    logic [4:0] ena_h  = '0;
    logic [4:0] sclr_h = '0;
    while (!seen && cyc < 8) begin
      tick();
      cyc++;
      if (cyc == 1) begin
        if (!hold) bus.start = 1'b0;
        bus.dataa = na;
        bus.datab = nb;
      end
      if (bus.busy) busy_n++;
      if (cyc <= 5) begin
        ena_h  = {bus.reg_clk_ena, ena_h[4:1]};
        sclr_h = {bus.reg_sclr_n, sclr_h[4:1]};
      end
      if (bus.done_flag) seen = 1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'd5);
    check({tag, "_product"}, 32'(bus.product), 32'(exp));
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'd4);
    check({tag, "_reg_clk_ena"}, 32'(ena_h), 32'b10001);
    check({tag, "_reg_sclr_n"}, 32'(sclr_h), 32'b11110);
  endtask

  initial begin
    logic [7:0] da [8];
    logic [7:0] db [8];
    logic [7:0] ra, rb;
    bit         bad;

    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.dataa = 8'h00;
    bus.datab = 8'h00;
    tick();
    tick();
    check("rst_product", 32'(bus.product), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done_flag), 32'd0);
    check("rst_ena", 32'(bus.reg_clk_ena), 32'd0);
    check("rst_sclr_n", 32'(bus.reg_sclr_n), 32'd1);

    // First start lands on the very first edge after reset release.
    reset_n = 1'b1;
    launch(8'h12, 8'h34);
    wait_done("first_12x34", ref_mul(8'h12, 8'h34), 1'b0, 8'hAA, 8'h55);
    tick();
    check("done_to_idle_busy", 32'(bus.busy), 32'd0);
    check("done_to_idle_done", 32'(bus.done_flag), 32'd0);

    da = '{8'hFF, 8'h00, 8'h80, 8'hFF, 8'h80, 8'h7F, 8'h01, 8'h0F};
    db = '{8'hFF, 8'hFF, 8'h80, 8'h02, 8'h01, 8'h80, 8'h00, 8'h0F};
    for (int i = 0; i < 8; i++) begin
      launch(da[i], db[i]);
      wait_done($sformatf("dir%0d_%02hx_%02hx", i, da[i], db[i]), ref_mul(da[i], db[i]),
                1'b0, 8'h5A, 8'hC3);
      tick();
    end

`ifdef MULT_SIGNED_EN
    check("signed_model_ff_02", 32'(ref_mul(8'hFF, 8'h02)), 32'hFFFE);
`else
    check("unsigned_model_ff_ff", 32'(ref_mul(8'hFF, 8'hFF)), 32'hFE01);
`endif

    // A second start during MID1 must be ignored.
    launch(8'h0F, 8'h0F);
    tick();
    bus.start = 1'b0;
    tick();
    launch(8'hFF, 8'hFF);
    tick();
    bus.start = 1'b0;
    tick();
    check("ignore_mid_busy", 32'(bus.busy), 32'd1);
    tick();
    check("ignore_done", 32'(bus.done_flag), 32'd1);
    check("ignore_product", 32'(bus.product), 32'(ref_mul(8'h0F, 8'h0F)));
    tick();
    check("ignore_back_idle", 32'(bus.busy), 32'd0);

    // Reset asserted mid-operation (MID2), released straight into a new start.
    launch(8'h05, 8'h07);
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("abort_product", 32'(bus.product), 32'h0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done_flag), 32'd0);
    check("abort_ena", 32'(bus.reg_clk_ena), 32'd0);
    check("abort_sclr_n", 32'(bus.reg_sclr_n), 32'd1);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.done_flag || bus.reg_clk_ena || bus.busy) bad = 1;
    end
    check("abort_quiet", 32'(bad), 32'd0);
    reset_n = 1'b1;
    launch(8'h02, 8'h03);
    wait_done("after_abort", ref_mul(8'h02, 8'h03), 1'b0, 8'hEE, 8'hEE);
    tick();

    // Back-to-back: start held high through DONE.
    launch(8'h10, 8'h10);
    wait_done("b2b_first", ref_mul(8'h10, 8'h10), 1'b1, 8'h03, 8'h05);
    wait_done("b2b_second", ref_mul(8'h03, 8'h05), 1'b0, 8'h99, 8'h66);
    tick();

    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      launch(ra, rb);
      wait_done($sformatf("rnd%0d_%02hx_%02hx", i, ra, rb), ref_mul(ra, rb),
                1'b0, 8'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
